// File: rtl/alu_share_arbiter_pkg.sv
// alu_share_arbiter_pkg
//   Shared definitions for the shared-ALU arbiter:
//   - RES_W        : width of the shared ALU datapath (fixed at 4)
//   - OP_ADD..OP_XOR : supported opcodes; every other opcode is an error
//   - state_t      : IDLE / EXEC / RESP controller states
//   - alu_out_t    : result plus unsupported-opcode flag
//   - alu_eval     : the 4-bit ALU core, evaluated on latched operands
package alu_share_arbiter_pkg;

  localparam int RES_W = 4;

  localparam logic [2:0] OP_ADD = 3'b000;
  localparam logic [2:0] OP_SUB = 3'b001;
  localparam logic [2:0] OP_AND = 3'b010;
  localparam logic [2:0] OP_OR  = 3'b011;
  localparam logic [2:0] OP_XOR = 3'b100;

  typedef enum logic [1:0] {
    ST_IDLE = 2'd0,
    ST_EXEC = 2'd1,
    ST_RESP = 2'd2
  } state_t;

  typedef struct packed {
    logic [RES_W-1:0] result;
    logic             err;
  } alu_out_t;

  // Arithmetic wraps modulo 2^RES_W. Unsupported opcodes give a zero
  // result with err set; the transaction still completes.
  function automatic alu_out_t alu_eval(input logic [RES_W-1:0] a,
                                        input logic [RES_W-1:0] b,
                                        input logic [2:0]       op);
    alu_out_t r;
    r.result = '0;
    r.err    = 1'b0;
    case (op)
      OP_ADD:  r.result = a + b;
      OP_SUB:  r.result = a - b;
      OP_AND:  r.result = a & b;
      OP_OR:   r.result = a | b;
      OP_XOR:  r.result = a ^ b;
      default: r.err    = 1'b1;
    endcase
    return r;
  endfunction

endpackage

// File: rtl/alu_rr_arbiter.sv
// alu_rr_arbiter
//   Combinational round-robin pick. Searches req_valid upward from ptr,
//   wrapping modulo N_REQ, and returns the first asserted requester.
// Ports:
//   valid  in  N_REQ   request lines
//   ptr    in  IW      highest-priority index this cycle
//   grant  out N_REQ   one-hot grant (zero when nothing is valid)
//   idx    out IW      index of the granted requester
//   any    out 1       at least one request is valid
module alu_rr_arbiter #(
  parameter int N_REQ = 4,
  parameter int IW    = $clog2(N_REQ)
) (
  input  logic [N_REQ-1:0] valid,
  input  logic [IW-1:0]    ptr,
  output logic [N_REQ-1:0] grant,
  output logic [IW-1:0]    idx,
  output logic             any
);

  // cand[k] = (ptr + k) mod N_REQ; N_REQ need not be a power of two, so the
  // wrap is an explicit subtract rather than a natural overflow.
  logic [IW-1:0] cand [N_REQ];

  genvar gi;
  generate
    for (gi = 0; gi < N_REQ; gi++) begin : g_cand
      logic [IW:0] sum;
      assign sum = {1'b0, ptr} + (IW+1)'(gi);
      assign cand[gi] = (sum >= (IW+1)'(N_REQ)) ? IW'(sum - (IW+1)'(N_REQ))
                                                 : IW'(sum);
    end
  endgenerate

  // Walk offsets from farthest to nearest so the nearest valid one wins.
  always_comb begin
    idx = '0;
    any = 1'b0;
    for (int k = N_REQ - 1; k >= 0; k--) begin
      if (valid[cand[k]]) begin
        idx = cand[k];
        any = 1'b1;
      end
    end
  end

  assign grant = any ? (N_REQ'(1) << idx) : '0;

endmodule

// File: rtl/alu_share_arbiter.sv
// alu_share_arbiter
//   Shares one 4-bit ALU among N_REQ requesters. IDLE grants round-robin and
//   latches the winner's operands, EXEC registers the ALU result, RESP holds
//   a tagged result until the consumer accepts it.
// Ports:
//   clk, rst              clock, synchronous active-high reset
//   req_valid/req_ready   per-requester handshake (ready one-hot or zero)
//   req_a, req_b          packed operands, requester i at [i*W +: W]
//   req_op                packed opcodes, requester i at [i*3 +: 3]
//   rsp_valid/rsp_ready   result handshake
//   rsp_id                requester owning the result
//   rsp_result, rsp_err   ALU result and unsupported-opcode flag
//   busy                  controller not in IDLE
//   op_count              completed responses, wraps
module alu_share_arbiter
  import alu_share_arbiter_pkg::*;
#(
  parameter int N_REQ = 4,
  parameter int W     = RES_W,
  parameter int CNT_W = 16
) (
  input  logic                     clk,
  input  logic                     rst,
  input  logic [N_REQ-1:0]         req_valid,
  output logic [N_REQ-1:0]         req_ready,
  input  logic [N_REQ*W-1:0]       req_a,
  input  logic [N_REQ*W-1:0]       req_b,
  input  logic [N_REQ*3-1:0]       req_op,
  output logic                     rsp_valid,
  input  logic                     rsp_ready,
  output logic [$clog2(N_REQ)-1:0] rsp_id,
  output logic [W-1:0]             rsp_result,
  output logic                     rsp_err,
  output logic                     busy,
  output logic [CNT_W-1:0]         op_count
);

  localparam int IW = $clog2(N_REQ);

  state_t           state_reg, state_next;
  logic [IW-1:0]    ptr_reg, ptr_next;
  logic [IW-1:0]    gnt_id_reg;
  logic [W-1:0]     a_reg, b_reg;
  logic [2:0]       op_reg;
  logic [W-1:0]     result_reg;
  logic             err_reg;
  logic [CNT_W-1:0] op_count_reg, op_count_next;

  logic             load_req, load_res;
  logic [N_REQ-1:0] ready_comb;
  logic             rsp_valid_comb;

  logic [N_REQ-1:0] arb_grant;
  logic [IW-1:0]    arb_idx;
  logic             arb_any;
  alu_out_t         alu_out;

  alu_rr_arbiter #(
    .N_REQ (N_REQ),
    .IW    (IW)
  ) u_arb (
    .valid (req_valid),
    .ptr   (ptr_reg),
    .grant (arb_grant),
    .idx   (arb_idx),
    .any   (arb_any)
  );

  assign alu_out = alu_eval(a_reg, b_reg, op_reg);

  always_comb begin
    state_next     = state_reg;
    ptr_next       = ptr_reg;
    op_count_next  = op_count_reg;
    load_req       = 1'b0;
    load_res       = 1'b0;
    ready_comb     = '0;
    rsp_valid_comb = 1'b0;
    case (state_reg)
      ST_IDLE: begin
        if (arb_any) begin
          ready_comb = arb_grant;
          load_req   = 1'b1;
          state_next = ST_EXEC;
        end
      end
      ST_EXEC: begin
        load_res   = 1'b1;
        state_next = ST_RESP;
      end
      ST_RESP: begin
        rsp_valid_comb = 1'b1;
        if (rsp_ready) begin
          op_count_next = op_count_reg + CNT_W'(1);
          // Priority moves just past the requester that was served.
          ptr_next      = (gnt_id_reg == IW'(N_REQ - 1)) ? '0
                                                         : gnt_id_reg + IW'(1);
          state_next    = ST_IDLE;
        end
      end
      default: state_next = ST_IDLE;
    endcase
  end

  always_ff @(posedge clk) begin
    if (rst) begin
      state_reg    <= ST_IDLE;
      ptr_reg      <= '0;
      gnt_id_reg   <= '0;
      a_reg        <= '0;
      b_reg        <= '0;
      op_reg       <= '0;
      result_reg   <= '0;
      err_reg      <= 1'b0;
      op_count_reg <= '0;
    end else begin
      state_reg    <= state_next;
      ptr_reg      <= ptr_next;
      op_count_reg <= op_count_next;
      if (load_req) begin
        gnt_id_reg <= arb_idx;
        a_reg      <= req_a[int'(arb_idx)*W +: W];
        b_reg      <= req_b[int'(arb_idx)*W +: W];
        op_reg     <= req_op[int'(arb_idx)*3 +: 3];
      end
      if (load_res) begin
        result_reg <= alu_out.result;
        err_reg    <= alu_out.err;
      end
    end
  end

  // Handshake outputs are masked while reset is asserted so no transfer can
  // be observed by a neighbour during the reset cycle itself.
  assign req_ready  = rst ? '0 : ready_comb;
  assign rsp_valid  = rsp_valid_comb & ~rst;
  assign rsp_id     = gnt_id_reg;
  assign rsp_result = result_reg;
  assign rsp_err    = err_reg;
  assign busy       = (state_reg != ST_IDLE);
  assign op_count   = op_count_reg;

endmodule

// File: tb/tb_alu_share_arbiter.sv
module tb_alu_share_arbiter;

  localparam int N = 4;
  localparam int W = 4;

  logic           clk = 1'b0;
  logic           rst;
  logic [N-1:0]   req_valid;
  logic [N-1:0]   req_ready;
  logic [N*W-1:0] req_a;
  logic [N*W-1:0] req_b;
  logic [N*3-1:0] req_op;
  logic           rsp_valid;
  logic           rsp_ready;
  logic [1:0]     rsp_id;
  logic [W-1:0]   rsp_result;
  logic           rsp_err;
  logic           busy;
  logic [15:0]    op_count;

  int checks = 0;
  int errors = 0;
  int exp_count = 0;

  alu_share_arbiter #(.N_REQ(N), .W(W), .CNT_W(16)) dut (
    .clk        (clk),
    .rst        (rst),
    .req_valid  (req_valid),
    .req_ready  (req_ready),
    .req_a      (req_a),
    .req_b      (req_b),
    .req_op     (req_op),
    .rsp_valid  (rsp_valid),
    .rsp_ready  (rsp_ready),
    .rsp_id     (rsp_id),
    .rsp_result (rsp_result),
    .rsp_err    (rsp_err),
    .busy       (busy),
    .op_count   (op_count)
  );

  always #5 clk = ~clk;

  typedef struct {
    int         id;
    logic [2:0] op;
    logic [3:0] a;
    logic [3:0] b;
    logic [3:0] res;
    logic       err;
  } vec_t;

  vec_t vecs[10];

  task automatic chk(input string nm, input logic [31:0] act, input logic [31:0] exp);
    checks++;
    if (act !== exp) begin
      errors++;
      $display("FAIL %s actual=%0h expected=%0h at %0t", nm, act, exp, $time);
    end
  endtask

  task automatic set_req(input int id, input logic [2:0] op,
                         input logic [3:0] a, input logic [3:0] b);
    req_valid[id]       = 1'b1;
    req_a[id*4 +: 4]    = a;
    req_b[id*4 +: 4]    = b;
    req_op[id*3 +: 3]   = op;
  endtask

  task automatic do_reset();
    @(negedge clk);
    rst = 1'b1;
    req_valid = '0;
    @(negedge clk);
    @(negedge clk);
    chk("rst_req_ready", 32'(req_ready), 32'h0);
    chk("rst_rsp_valid", 32'(rsp_valid), 32'h0);
    chk("rst_rsp_id", 32'(rsp_id), 32'h0);
    chk("rst_rsp_result", 32'(rsp_result), 32'h0);
    chk("rst_rsp_err", 32'(rsp_err), 32'h0);
    chk("rst_busy", 32'(busy), 32'h0);
    chk("rst_op_count", 32'(op_count), 32'h0);
    rst = 1'b0;
    exp_count = 0;
  endtask

  // Starts and ends at a negedge with the controller in IDLE, rsp_ready=1.
  task automatic run_vec(input vec_t v);
    logic [3:0] onehot;
    onehot = 4'b0001 << v.id;
    set_req(v.id, v.op, v.a, v.b);
    #1;
    chk("grant", 32'(req_ready), 32'(onehot));
    chk("idle_busy", 32'(busy), 32'h0);
    @(negedge clk);
    req_valid = '0;
    #1;
    chk("exec_rsp_valid", 32'(rsp_valid), 32'h0);
    chk("exec_busy", 32'(busy), 32'h1);
    chk("exec_ready", 32'(req_ready), 32'h0);
    @(negedge clk);
    chk("rsp_valid", 32'(rsp_valid), 32'h1);
    chk("rsp_id", 32'(rsp_id), 32'(v.id));
    chk("rsp_result", 32'(rsp_result), 32'(v.res));
    chk("rsp_err", 32'(rsp_err), 32'(v.err));
    @(negedge clk);
    exp_count++;
    chk("op_count", 32'(op_count), 32'(exp_count));
    chk("post_rsp_valid", 32'(rsp_valid), 32'h0);
    $display("txn r%0d op=%b a=%h b=%h -> result=%h err=%0b count=%0d",
             v.id, v.op, v.a, v.b, rsp_result, rsp_err, op_count);
  endtask

  initial begin : watchdog
    #200000;
    $display("FAIL watchdog timeout");
    $fatal(1, "timeout");
  end

  initial begin
    vecs[0] = '{0, 3'b000, 4'h7, 4'h9, 4'h0, 1'b0};
    vecs[1] = '{2, 3'b001, 4'h3, 4'h5, 4'hE, 1'b0};
    vecs[2] = '{2, 3'b100, 4'hA, 4'h6, 4'hC, 1'b0};
    vecs[3] = '{1, 3'b110, 4'hF, 4'hF, 4'h0, 1'b1};
    vecs[4] = '{3, 3'b010, 4'hC, 4'hA, 4'h8, 1'b0};
    vecs[5] = '{1, 3'b011, 4'h5, 4'hA, 4'hF, 1'b0};
    vecs[6] = '{0, 3'b001, 4'h0, 4'h1, 4'hF, 1'b0};
    vecs[7] = '{3, 3'b111, 4'h1, 4'h2, 4'h0, 1'b1};
    vecs[8] = '{2, 3'b101, 4'h4, 4'h4, 4'h0, 1'b1};
    vecs[9] = '{0, 3'b000, 4'hF, 4'h1, 4'h0, 1'b0};

    rst = 1'b1;
    req_valid = '0;
    req_a = '0;
    req_b = '0;
    req_op = '0;
    rsp_ready = 1'b1;
    do_reset();

    for (int i = 0; i < 10; i++) run_vec(vecs[i]);

    // Persistent all-valid load: grants 0,1,2,3,0, one every 3 cycles.
    do_reset();
    for (int i = 0; i < N; i++) set_req(i, 3'b000, 4'(i), 4'h1);
    for (int k = 0; k < 5; k++) begin
      int g;
      logic [3:0] onehot;
      g = k % N;
      onehot = 4'b0001 << g;
      #1;
      chk("rr_grant", 32'(req_ready), 32'(onehot));
      @(negedge clk);
      @(negedge clk);
      chk("rr_rsp_id", 32'(rsp_id), 32'(g));
      chk("rr_result", 32'(rsp_result), 32'(g + 1));
      if (k == 4) req_valid = '0;
      @(negedge clk);
      exp_count++;
      chk("rr_op_count", 32'(op_count), 32'(exp_count));
      $display("rr grant %0d result=%h count=%0d", g, rsp_result, op_count);
    end

    // Backpressure: r0 served, r3 arrives during EXEC, rsp_ready low 4 cycles.
    rsp_ready = 1'b0;
    set_req(0, 3'b000, 4'h1, 4'h2);
    #1;
    chk("bp_grant0", 32'(req_ready), 32'h1);
    @(negedge clk);
    req_valid = '0;
    set_req(3, 3'b010, 4'hC, 4'hA);
    #1;
    chk("bp_exec_ready", 32'(req_ready), 32'h0);
    for (int c = 0; c < 4; c++) begin
      @(negedge clk);
      chk("bp_rsp_valid", 32'(rsp_valid), 32'h1);
      chk("bp_rsp_id", 32'(rsp_id), 32'h0);
      chk("bp_result", 32'(rsp_result), 32'h3);
      chk("bp_ready", 32'(req_ready), 32'h0);
      chk("bp_op_count", 32'(op_count), 32'(exp_count));
      $display("bp hold cycle %0d result=%h ready=%b", c, rsp_result, req_ready);
    end
    rsp_ready = 1'b1;
    @(negedge clk);
    exp_count++;
    #1;
    chk("bp_count_after", 32'(op_count), 32'(exp_count));
    chk("bp_grant3", 32'(req_ready), 32'h8);
    @(negedge clk);
    req_valid = '0;
    @(negedge clk);
    chk("bp_r3_id", 32'(rsp_id), 32'h3);
    chk("bp_r3_result", 32'(rsp_result), 32'h8);
    @(negedge clk);
    exp_count++;
    chk("bp_r3_count", 32'(op_count), 32'(exp_count));
    $display("bp r3 served count=%0d", op_count);

    // Reset during EXEC discards the in-flight transaction.
    set_req(2, 3'b000, 4'h5, 4'h5);
    #1;
    chk("rx_grant2", 32'(req_ready), 32'h4);
    @(negedge clk);
    req_valid = '0;
    rst = 1'b1;
    @(negedge clk);
    chk("rx_rsp_valid", 32'(rsp_valid), 32'h0);
    chk("rx_busy", 32'(busy), 32'h0);
    chk("rx_op_count", 32'(op_count), 32'h0);
    chk("rx_rsp_id", 32'(rsp_id), 32'h0);
    chk("rx_result", 32'(rsp_result), 32'h0);
    rst = 1'b0;
    exp_count = 0;
    set_req(0, 3'b000, 4'h2, 4'h2);
    set_req(1, 3'b001, 4'h9, 4'h2);
    #1;
    chk("rx_grant0_first", 32'(req_ready), 32'h1);
    @(negedge clk);
    req_valid[0] = 1'b0;
    #1;
    chk("rx_exec_no_rsp", 32'(rsp_valid), 32'h0);
    @(negedge clk);
    chk("rx_r0_id", 32'(rsp_id), 32'h0);
    chk("rx_r0_result", 32'(rsp_result), 32'h4);
    @(negedge clk);
    exp_count++;
    #1;
    chk("rx_grant1", 32'(req_ready), 32'h2);
    @(negedge clk);
    req_valid = '0;
    @(negedge clk);
    chk("rx_r1_id", 32'(rsp_id), 32'h1);
    chk("rx_r1_result", 32'(rsp_result), 32'h7);
    @(negedge clk);
    exp_count++;
    chk("rx_final_count", 32'(op_count), 32'(exp_count));
    $display("reset-exec sequence count=%0d", op_count);

    $display("CHECKS %0d ERRORS %0d", checks, errors);
    $finish;
  end

endmodule

// File: doc/alu_share_arbiter.md
# alu_share_arbiter

Shares one 4-bit combinational ALU datapath (ADD, SUB, AND, OR, XOR) among N requesters. Each requester issues one operation at a time, with operands and opcode, over a valid/ready handshake. The block grants requesters round-robin, registers the operands, runs the ALU, and returns a registered, tagged result over a second valid/ready handshake. It sits between the requesting control units and the shared ALU instance.

## Interface
Parameters:
- N_REQ, 4, number of requesters (2..8)
- W, 4, operand/result width (fixed 4 for the shared ALU)
- CNT_W, 16, width of completed-operation counter

Ports:
- clk  in  1  single clock, rising edge
- rst  in  1  synchronous, active-high reset
- req_valid  in  N_REQ  per-requester request valid
- req_ready  out  N_REQ  per-requester accept (one-hot or zero)
- req_a  in  N_REQ*W  operand A, requester i at bits [i*W +: W]
- req_b  in  N_REQ*W  operand B, same packing
- req_op  in  N_REQ*3  opcode, requester i at [i*3 +: 3]
- rsp_valid  out  1  result valid
- rsp_ready  in  1  result accepted by consumer
- rsp_id  out  $clog2(N_REQ)  index of the requester owning the result
- rsp_result  out  W  ALU result
- rsp_err  out  1  opcode was unsupported (101..111)
- busy  out  1  high in any state other than IDLE
- op_count  out  CNT_W  completed (handshaken) responses, wraps

## Operation
- The reset and clock polarity above are fixed: one clock, synchronous active-high reset.
- FSM states: IDLE, EXEC, RESP.
- **IDLE**
  - Grant g is the first asserted req_valid found searching upward from ptr, wrapping modulo N_REQ.
  - req_ready[g]=1 combinationally in the same cycle; the handshake completes that cycle.
  - a/b/op of g are latched, g is latched into gnt_id, and the FSM goes to EXEC.
  - If no req_valid is asserted, the FSM stays in IDLE and req_ready=0.
- **EXEC**
  - ALU evaluates the latched operands.
  - Result and err are registered; the FSM goes to RESP.
  - req_ready=0.
- **RESP**
  - rsp_valid=1, rsp_id=gnt_id, and rsp_result/rsp_err are held stable.
  - On rsp_valid & rsp_ready: op_count increments, ptr becomes (gnt_id+1) mod N_REQ, and the FSM goes to IDLE.
- **Arithmetic**
  - Results are modulo 2^W: ADD 000, SUB 001 (two's complement wrap), AND 010, OR 011, XOR 100.
  - Opcodes 101..111 give result 0 and rsp_err=1; the transaction still completes normally.
- Requesters must hold valid and operands stable until ready. The block does not depend on req_valid after the grant.
- Only IDLE samples requests. A request arriving in EXEC or RESP waits.
- A deasserted req_valid is simply skipped. No grant is held across cycles.
- op_count wraps from 2^CNT_W−1 to 0.

## Timing
- **Reset values:** state=IDLE, ptr=0, req_ready=0, rsp_valid=0, rsp_id=0, rsp_result=0, rsp_err=0, busy=0, op_count=0.
- **Latency:** request accepted at edge T gives rsp_valid high from T+2. Minimum issue interval is 3 cycles with rsp_ready tied high.
- **Backpressure:** rsp_ready low holds RESP indefinitely with outputs stable. No new grants occur in that time.
- **Reset mid-operation:** the in-flight transaction is discarded with no response; ptr returns to 0.
- **Simultaneous requests:** exactly one grant per IDLE cycle. Under persistent all-valid load, grants go 0,1,2,…,N_REQ−1,0.

## Structure
- Shared package holds the opcode localparams (OP_ADD..OP_XOR), the FSM state enum, and the result width constant.
- Natural sub-module: alu_rr_arbiter, a combinational round-robin pick of (req_valid, ptr) producing a one-hot grant and an index.
- The ALU datapath is the existing 4-bit ALU core, instantiated once on the latched operands.

## Test plan
- Single request, r0 op=000 a=7 b=9 accepted at T: rsp_valid at T+2, rsp_id=0, result=0x0, err=0, op_count=1.
- r2 op=001 a=3 b=5: result=0xE. Then r2 op=100 a=0xA b=0x6: result=0xC.
- All four requests held valid with rsp_ready=1: grant order 0,1,2,3,0, one response every 3 cycles, ptr wraps.
- r1 op=110 a=0xF b=0xF: result=0, err=1, op_count increments.
- rsp_ready low for 4 cycles in RESP while r3 is valid: rsp outputs stable, req_ready stays 0, r3 granted only after the RESP handshake.
- rst pulsed during EXEC: no rsp_valid, all outputs return to reset values, and the next request at r0 and r1 grants r0 first.
